// File: rtl/i2c_cmd_pkg.sv
// -----------------------------------------------------------------------------
// i2c_cmd_pkg
// Shared definitions for the I2C command-port arbiter and its requesters.
//   - arb_state_e   : arbiter FSM states (IDLE / ISSUE / GAP)
//   - CMD_ADDR_*    : command-port addresses used by requesters
//   - CMD_I2C_*     : I2C sub-command byte carried in cmd_data[31:24]
//   - rr_next()     : wrap-around increment of a requester index
// -----------------------------------------------------------------------------
package i2c_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam logic [5:0] CMD_ADDR_I2C  = 6'h3d;
    localparam logic [5:0] CMD_ADDR_GEN  = 6'h00;
    localparam logic [7:0] CMD_I2C_WRITE = 8'h06;

    // Next requester index after idx, wrapping at n.
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int unsigned n);
        logic [2:0] nxt;
        if (idx == 3'(n - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_cmd_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first set request at or
// after the pointer, wrapping modulo NREQ.
//   i_req   [NREQ-1:0] : request vector
//   i_ptr   [2:0]      : highest-priority index this round (must be < NREQ)
//   o_found            : at least one request is set
//   o_idx   [2:0]      : selected index (0 when nothing found)
// -----------------------------------------------------------------------------
module rr_pick
    import i2c_cmd_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [2:0]      i_ptr,
    output logic            o_found,
    output logic [2:0]      o_idx
);

    // Padding to 8 entries lets a 3-bit index address the vector for any NREQ.
    logic [7:0] w_req8;
    logic [3:0] w_cand;

    assign w_req8 = 8'(i_req);

    // Scan NREQ candidate slots starting at the pointer; first hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = 3'd0;
        w_cand  = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, i_ptr} + 4'(k);
            // ptr < NREQ, so one subtraction always folds back into range.
            if (w_cand >= 4'(NREQ)) begin
                w_cand = w_cand - 4'(NREQ);
            end else begin
                w_cand = w_cand;
            end
            if (!o_found && w_req8[w_cand[2:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[2:0];
            end else begin
                o_found = o_found;
                o_idx   = o_idx;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arb.sv
// -----------------------------------------------------------------------------
// i2c_cmd_arb
// Round-robin arbiter sharing one I2C command slave port among NREQ
// requesters. One request is latched per grant and held on cmd_* until the
// downstream acknowledges it or the timeout drops it; a hold-off gap then
// separates consecutive grants so downstream busy status can settle.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req_addr/data/rqst     : per-requester command (slice i = requester i)
//   req_ack / req_nak      : one-cycle accept / timeout-drop pulses
//   cmd_addr/data/rqst     : command to the I2C command port
//   cmd_ack                : acknowledge from the command port
//   grant_valid            : a command is currently held
//   grant_idx              : index of the current or most recent grant
// All outputs are registered.
// -----------------------------------------------------------------------------
module i2c_cmd_arb
    import i2c_cmd_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 4096,
    parameter int HOLDOFF = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_rqst,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_nak,
    output logic [5:0]           cmd_addr,
    output logic [31:0]          cmd_data,
    output logic                 cmd_rqst,
    input  logic                 cmd_ack,
    output logic                 grant_valid,
    output logic [2:0]           grant_idx
);

    arb_state_e       r_state, w_state_nxt;
    logic [15:0]      r_timer, w_timer_nxt;
    logic [7:0]       r_hold, w_hold_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [5:0]       r_cmd_addr, w_cmd_addr_nxt;
    logic [31:0]      r_cmd_data, w_cmd_data_nxt;
    logic             r_cmd_rqst, w_cmd_rqst_nxt;
    logic             r_grant_valid, w_grant_valid_nxt;
    logic [2:0]       r_grant_idx, w_grant_idx_nxt;
    logic [NREQ-1:0]  r_req_ack, w_req_ack_nxt;
    logic [NREQ-1:0]  r_req_nak, w_req_nak_nxt;

    logic             w_found;
    logic [2:0]       w_pick;
    logic [7:0]       w_grant_1h8;
    logic [NREQ-1:0]  w_grant_1h;
    logic [5:0]       w_addr_arr [8];
    logic [31:0]      w_data_arr [8];

    // Unpack the flat requester buses into 8-entry arrays (unused slots 0).
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        if (gi < NREQ) begin : g_used
            assign w_addr_arr[gi] = req_addr[6*gi +: 6];
            assign w_data_arr[gi] = req_data[32*gi +: 32];
        end else begin : g_unused
            assign w_addr_arr[gi] = 6'd0;
            assign w_data_arr[gi] = 32'd0;
        end
    end

    assign w_grant_1h8 = 8'd1 << r_grant_idx;
    assign w_grant_1h  = w_grant_1h8[NREQ-1:0];

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req   (req_rqst),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_hold_nxt        = r_hold;
        w_ptr_nxt         = r_ptr;
        w_cmd_addr_nxt    = r_cmd_addr;
        w_cmd_data_nxt    = r_cmd_data;
        w_cmd_rqst_nxt    = r_cmd_rqst;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_idx_nxt   = r_grant_idx;
        w_req_ack_nxt     = {NREQ{1'b0}};
        w_req_nak_nxt     = {NREQ{1'b0}};
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_cmd_addr_nxt    = w_addr_arr[w_pick];
                    w_cmd_data_nxt    = w_data_arr[w_pick];
                    w_cmd_rqst_nxt    = 1'b1;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_idx_nxt   = w_pick;
                    w_timer_nxt       = 16'd0;
                    w_state_nxt       = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                // Ack is tested first so it wins over a coinciding timeout.
                if (cmd_ack) begin
                    w_req_ack_nxt     = w_grant_1h;
                    w_cmd_rqst_nxt    = 1'b0;
                    w_grant_valid_nxt = 1'b0;
                    w_ptr_nxt         = rr_next(r_grant_idx, NREQ);
                    w_hold_nxt        = 8'd0;
                    w_state_nxt       = GAP;
                end else if (r_timer == 16'(TIMEOUT - 1)) begin
                    w_req_nak_nxt     = w_grant_1h;
                    w_cmd_rqst_nxt    = 1'b0;
                    w_grant_valid_nxt = 1'b0;
                    w_ptr_nxt         = rr_next(r_grant_idx, NREQ);
                    w_hold_nxt        = 8'd0;
                    w_state_nxt       = GAP;
                end else if (r_timer != 16'hffff) begin
                    w_timer_nxt = r_timer + 16'd1;
                end else begin
                    w_timer_nxt = r_timer;
                end
            end
            GAP: begin
                if (r_hold == 8'(HOLDOFF - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt       = IDLE;
                w_cmd_rqst_nxt    = 1'b0;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_timer       <= 16'd0;
            r_hold        <= 8'd0;
            r_ptr         <= 3'd0;
            r_cmd_addr    <= 6'd0;
            r_cmd_data    <= 32'd0;
            r_cmd_rqst    <= 1'b0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= 3'd0;
            r_req_ack     <= {NREQ{1'b0}};
            r_req_nak     <= {NREQ{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_hold        <= w_hold_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cmd_addr    <= w_cmd_addr_nxt;
            r_cmd_data    <= w_cmd_data_nxt;
            r_cmd_rqst    <= w_cmd_rqst_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_req_ack     <= w_req_ack_nxt;
            r_req_nak     <= w_req_nak_nxt;
        end
    end

    assign req_ack     = r_req_ack;
    assign req_nak     = r_req_nak;
    assign cmd_addr    = r_cmd_addr;
    assign cmd_data    = r_cmd_data;
    assign cmd_rqst    = r_cmd_rqst;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;

endmodule
